// File: rtl/i8255_sched.sv
// i8255_sched: round-robin scheduler for two requesters, sequencing each access onto the i8255 CPU bus
// with programmable setup/strobe/hold phases. Define I8255_SCHED_INIT_EN for a start-up control-word write.
module i8255_sched #(
    parameter int unsigned SETUP_CYC  = 1,
    parameter int unsigned STROBE_CYC = 2,
    parameter int unsigned HOLD_CYC   = 1,
    parameter logic [7:0]  INIT_CTRL  = 8'h9B
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0,
    input  logic       req1,
    input  logic       we0,
    input  logic       we1,
    input  logic [1:0] addr0,
    input  logic [1:0] addr1,
    input  logic [7:0] wdata0,
    input  logic [7:0] wdata1,
    output logic       ack0,
    output logic       ack1,
    output logic [7:0] rdata,
    output logic       busy,
    output logic       cs,
    output logic       rd,
    output logic       wr,
    output logic [1:0] a,
    output logic [7:0] dout,
    input  logic [7:0] din
);

    localparam int unsigned CW = 4;
    localparam int unsigned AW = 2;
    localparam int unsigned DW = 8;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SETUP  = 3'd1;
    localparam logic [2:0] S_STROBE = 3'd2;
    localparam logic [2:0] S_HOLD   = 3'd3;
`ifdef I8255_SCHED_INIT_EN
    localparam logic [2:0] S_INIT   = 3'd4;
    localparam logic [2:0] S_RESET  = S_INIT;
`else
    localparam logic [2:0] S_RESET  = S_IDLE;
    logic unused_init;
    assign unused_init = ^INIT_CTRL;
`endif

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          port_q, port_d;
    logic          last_q, last_d;
    logic          we_q, we_d;
    logic          init_q, init_d;
    logic [AW-1:0] a_q, a_d;
    logic [DW-1:0] dout_q, dout_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          cs_q, cs_d, rd_q, rd_d, wr_q, wr_d, busy_q, busy_d;
    logic          ack0_q, ack0_d, ack1_q, ack1_d;
    logic          grant_c;
    logic          ack_c;

    // Contention goes to the port that was not served last; a lone requester always wins.
    assign grant_c = (req0 && req1) ? ~last_q : req1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_RESET;
            cnt_q   <= '0;
            port_q  <= 1'b0;
            last_q  <= 1'b1;
            we_q    <= 1'b0;
            init_q  <= 1'b0;
            a_q     <= '0;
            dout_q  <= '0;
            rdata_q <= '0;
            cs_q    <= 1'b0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            busy_q  <= 1'b0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            port_q  <= port_d;
            last_q  <= last_d;
            we_q    <= we_d;
            init_q  <= init_d;
            a_q     <= a_d;
            dout_q  <= dout_d;
            rdata_q <= rdata_d;
            cs_q    <= cs_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            busy_q  <= busy_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        port_d  = port_q;
        last_d  = last_q;
        we_d    = we_q;
        init_d  = init_q;
        a_d     = a_q;
        dout_d  = dout_q;
        rdata_d = rdata_q;

        case (state_q)
            S_IDLE: begin
                if (req0 || req1) begin
                    port_d  = grant_c;
                    last_d  = grant_c;
                    init_d  = 1'b0;
                    we_d    = grant_c ? we1 : we0;
                    a_d     = grant_c ? addr1 : addr0;
                    dout_d  = grant_c ? wdata1 : wdata0;
                    state_d = S_SETUP;
                    cnt_d   = CW'(SETUP_CYC - 1);
                end
            end
            S_SETUP: begin
                if (cnt_q == '0) begin
                    state_d = S_STROBE;
                    cnt_d   = CW'(STROBE_CYC - 1);
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_STROBE: begin
                if (cnt_q == '0) begin
                    state_d = S_HOLD;
                    cnt_d   = CW'(HOLD_CYC - 1);
                    if (!we_q) begin
                        rdata_d = din;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
`ifdef I8255_SCHED_INIT_EN
            S_INIT: begin
                init_d  = 1'b1;
                we_d    = 1'b1;
                a_d     = 2'b11;
                dout_d  = INIT_CTRL;
                state_d = S_SETUP;
                cnt_d   = CW'(SETUP_CYC - 1);
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Bus outputs are registered, so they are decoded from the state being entered.
        cs_d   = (state_d == S_SETUP) || (state_d == S_STROBE) || (state_d == S_HOLD);
        rd_d   = (state_d == S_STROBE) && !we_d;
        wr_d   = (state_d == S_STROBE) && we_d;
        busy_d = (state_d != S_IDLE);
        ack_c  = (state_d == S_HOLD) && (cnt_d == '0) && !init_d;
        ack0_d = ack_c && !port_d;
        ack1_d = ack_c && port_d;
    end

    assign ack0  = ack0_q;
    assign ack1  = ack1_q;
    assign rdata = rdata_q;
    assign busy  = busy_q;
    assign cs    = cs_q;
    assign rd    = rd_q;
    assign wr    = wr_q;
    assign a     = a_q;
    assign dout  = dout_q;

endmodule

// File: tb/tb_i8255_sched.sv
// tb_i8255_sched: directed bench for i8255_sched (default and swept timing) against a transaction-level model.
// Build with +define+I8255_SCHED_INIT_EN to cover the start-up control-word write.
`timescale 1ns/1ps
module tb_i8255_sched;

    localparam int S0 = 1, T0 = 2, H0 = 1;
    localparam int S1 = 3, T1 = 1, H1 = 2;
`ifdef I8255_SCHED_INIT_EN
    localparam bit INIT_BUILD = 1'b1;
`else
    localparam bit INIT_BUILD = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_s[2];
    logic       req0_s[2], req1_s[2], we0_s[2], we1_s[2];
    logic [1:0] addr0_s[2], addr1_s[2];
    logic [7:0] wdata0_s[2], wdata1_s[2], din_s[2];
    logic       ack0_o[2], ack1_o[2], busy_o[2], cs_o[2], rd_o[2], wr_o[2];
    logic [1:0] a_o[2];
    logic [7:0] dout_o[2], rdata_o[2];

    i8255_sched #(.SETUP_CYC(S0), .STROBE_CYC(T0), .HOLD_CYC(H0), .INIT_CTRL(8'h9B)) u0 (
        .clk(clk), .reset(rst_s[0]),
        .req0(req0_s[0]), .req1(req1_s[0]), .we0(we0_s[0]), .we1(we1_s[0]),
        .addr0(addr0_s[0]), .addr1(addr1_s[0]), .wdata0(wdata0_s[0]), .wdata1(wdata1_s[0]),
        .ack0(ack0_o[0]), .ack1(ack1_o[0]), .rdata(rdata_o[0]), .busy(busy_o[0]),
        .cs(cs_o[0]), .rd(rd_o[0]), .wr(wr_o[0]), .a(a_o[0]), .dout(dout_o[0]), .din(din_s[0])
    );

    i8255_sched #(.SETUP_CYC(S1), .STROBE_CYC(T1), .HOLD_CYC(H1), .INIT_CTRL(8'h9B)) u1 (
        .clk(clk), .reset(rst_s[1]),
        .req0(req0_s[1]), .req1(req1_s[1]), .we0(we0_s[1]), .we1(we1_s[1]),
        .addr0(addr0_s[1]), .addr1(addr1_s[1]), .wdata0(wdata0_s[1]), .wdata1(wdata1_s[1]),
        .ack0(ack0_o[1]), .ack1(ack1_o[1]), .rdata(rdata_o[1]), .busy(busy_o[1]),
        .cs(cs_o[1]), .rd(rd_o[1]), .wr(wr_o[1]), .a(a_o[1]), .dout(dout_o[1]), .din(din_s[1])
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic chk1(input string name, input int k, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d cyc=%0d got=%b want=%b", name, k, cyc, act, exp);
        end
    endtask

    task automatic chk8(input string name, input int k, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d cyc=%0d got=%h want=%h", name, k, cyc, act, exp);
        end
    endtask

    task automatic chkn(input string name, input int k, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s dut%0d cyc=%0d got=%0d want=%0d", name, k, cyc, act, exp);
        end
    endtask

    // Transaction model: a grant at cycle g owns the bus for cycles g+1..g+S+T+H.
    bit         have[2], mport[2], mwe[2], minit[2], mlast[2], init_pend[2];
    int         g[2];
    logic [1:0] ma[2];
    logic [7:0] md[2], mr[2];

    always @(negedge clk) begin
        int s, t, d;
        bit win, stb, ackx;
        for (int k = 0; k < 2; k++) begin
            s = (k == 1) ? S1 : S0;
            t = (k == 1) ? T1 : T0;
            d = s + t + ((k == 1) ? H1 : H0);
            if (!rst_s[k]) begin
                chk1("rst_cs", k, cs_o[k], 1'b0);
                chk1("rst_rd", k, rd_o[k], 1'b0);
                chk1("rst_wr", k, wr_o[k], 1'b0);
                chk1("rst_busy", k, busy_o[k], 1'b0);
                chk1("rst_ack0", k, ack0_o[k], 1'b0);
                chk1("rst_ack1", k, ack1_o[k], 1'b0);
                chk8("rst_a", k, 8'(a_o[k]), 8'h00);
                chk8("rst_dout", k, dout_o[k], 8'h00);
                chk8("rst_rdata", k, rdata_o[k], 8'h00);
                have[k] = 1'b0;
                mlast[k] = 1'b1;
                ma[k] = 2'd0;
                md[k] = 8'h00;
                mr[k] = 8'h00;
                init_pend[k] = INIT_BUILD;
            end else begin
                win  = have[k] && cyc > g[k] && cyc <= g[k] + d;
                stb  = have[k] && cyc > g[k] + s && cyc <= g[k] + s + t;
                ackx = have[k] && !minit[k] && cyc == g[k] + d;
                chk1("cs", k, cs_o[k], win);
                chk1("busy", k, busy_o[k], win);
                chk1("rd", k, rd_o[k], stb && !mwe[k]);
                chk1("wr", k, wr_o[k], stb && mwe[k]);
                chk1("ack0", k, ack0_o[k], ackx && !mport[k]);
                chk1("ack1", k, ack1_o[k], ackx && mport[k]);
                chk8("a", k, 8'(a_o[k]), 8'(ma[k]));
                chk8("dout", k, dout_o[k], md[k]);
                chk8("rdata", k, rdata_o[k], mr[k]);
                if (stb && cyc == g[k] + s + t && !mwe[k]) mr[k] = din_s[k];
                if (!have[k] || cyc > g[k] + d) begin
                    if (init_pend[k]) begin
                        init_pend[k] = 1'b0;
                        have[k] = 1'b1; g[k] = cyc; minit[k] = 1'b1;
                        mwe[k] = 1'b1; ma[k] = 2'd3; md[k] = 8'h9B;
                    end else if (req0_s[k] || req1_s[k]) begin
                        mport[k] = (req0_s[k] && req1_s[k]) ? !mlast[k] : req1_s[k];
                        mlast[k] = mport[k];
                        have[k] = 1'b1; g[k] = cyc; minit[k] = 1'b0;
                        mwe[k] = mport[k] ? we1_s[k] : we0_s[k];
                        ma[k]  = mport[k] ? addr1_s[k] : addr0_s[k];
                        md[k]  = mport[k] ? wdata1_s[k] : wdata0_s[k];
                    end
                end
            end
        end
    end

    logic [31:0] tr_cs, tr_wr, tr_rd, tr_ack;
    logic [1:0]  a_at2;
    logic [7:0]  d_at2, rd_ack;
    int          order[4], when[4];

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_ack(input int k, input bit p, input int c0, input int budget, output int lat);
        bit done;
        int rel;
        logic ackv;
        done = 1'b0;
        lat = -1;
        tr_cs = '0; tr_wr = '0; tr_rd = '0; tr_ack = '0;
        a_at2 = '0; d_at2 = '0; rd_ack = '0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk);
            rel = cyc - c0;
            ackv = p ? ack1_o[k] : ack0_o[k];
            if (rel >= 0 && rel < 32) begin
                tr_cs[rel] = cs_o[k];
                tr_wr[rel] = wr_o[k];
                tr_rd[rel] = rd_o[k];
                tr_ack[rel] = ackv;
            end
            if (rel == 2) begin
                a_at2 = a_o[k];
                d_at2 = dout_o[k];
            end
            if (ackv === 1'b1) begin
                lat = rel;
                rd_ack = rdata_o[k];
                done = 1'b1;
            end
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL ack_timeout dut%0d port%0d: no ack within %0d cycles, required one", k, p, budget);
        end
    endtask

    task automatic access(input int k, input bit p, input bit w, input logic [1:0] ad,
                          input logic [7:0] wd, output int lat);
        int c0;
        tick();
        if (p) begin
            we1_s[k] = w; addr1_s[k] = ad; wdata1_s[k] = wd; req1_s[k] = 1'b1;
        end else begin
            we0_s[k] = w; addr0_s[k] = ad; wdata0_s[k] = wd; req0_s[k] = 1'b1;
        end
        c0 = cyc;
        wait_ack(k, p, c0, 40, lat);
        tick();
        if (p) req1_s[k] = 1'b0;
        else   req0_s[k] = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench still running at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat, c0, n;
        bit seen;
        for (int k = 0; k < 2; k++) begin
            rst_s[k] = 1'b0;
            req0_s[k] = 1'b0; req1_s[k] = 1'b0; we0_s[k] = 1'b0; we1_s[k] = 1'b0;
            addr0_s[k] = 2'd0; addr1_s[k] = 2'd0;
            wdata0_s[k] = 8'h00; wdata1_s[k] = 8'h00; din_s[k] = 8'h00;
        end
        repeat (3) tick();

        // Request held through reset: serviced after the optional start-up write.
        req0_s[0] = 1'b1; we0_s[0] = 1'b1; addr0_s[0] = 2'd1; wdata0_s[0] = 8'h3C;
        tick();
        rst_s[0] = 1'b1;
        rst_s[1] = 1'b1;
        c0 = cyc;
        wait_ack(0, 1'b0, c0, 40, lat);
        chkn("held_req_latency", 0, lat, INIT_BUILD ? 9 : 4);
        chk1("first_wr_rel2", 0, tr_wr[2], 1'b1);
        chk8("first_a_rel2", 0, 8'(a_at2), INIT_BUILD ? 8'h03 : 8'h01);
        chk8("first_dout_rel2", 0, d_at2, INIT_BUILD ? 8'h9B : 8'h3C);
        tick();
        req0_s[0] = 1'b0;
        repeat (12) tick();

        // Single write with default timing.
        access(0, 1'b0, 1'b1, 2'd0, 8'h55, lat);
        chkn("wr_latency", 0, lat, 4);
        chk8("wr_cs_trace", 0, 8'(tr_cs[4:0]), 8'h1E);
        chk8("wr_wr_trace", 0, 8'(tr_wr[4:0]), 8'h0C);
        chk8("wr_rd_trace", 0, 8'(tr_rd[4:0]), 8'h00);
        chk8("wr_ack_trace", 0, 8'(tr_ack[4:0]), 8'h10);
        chk8("wr_a", 0, 8'(a_at2), 8'h00);
        chk8("wr_dout", 0, d_at2, 8'h55);

        // Single read from port 1.
        din_s[0] = 8'hA7;
        access(0, 1'b1, 1'b0, 2'd2, 8'h00, lat);
        chkn("rd_latency", 0, lat, 4);
        chk8("rd_rd_trace", 0, 8'(tr_rd[4:0]), 8'h0C);
        chk8("rd_wr_trace", 0, 8'(tr_wr[4:0]), 8'h00);
        chk8("rd_rdata", 0, rd_ack, 8'hA7);
        chk8("rd_a", 0, 8'(a_at2), 8'h02);

        // Contention: both held, grants alternate starting with port 0.
        tick();
        din_s[0] = 8'h5A;
        we0_s[0] = 1'b1; addr0_s[0] = 2'd1; wdata0_s[0] = 8'h11; req0_s[0] = 1'b1;
        we1_s[0] = 1'b0; addr1_s[0] = 2'd3; wdata1_s[0] = 8'h22; req1_s[0] = 1'b1;
        c0 = cyc;
        n = 0;
        for (int i = 0; i < 80 && n < 4; i++) begin
            @(negedge clk);
            if (ack0_o[0] === 1'b1 || ack1_o[0] === 1'b1) begin
                order[n] = int'(ack1_o[0]);
                when[n] = cyc;
                n++;
            end
        end
        tick();
        req0_s[0] = 1'b0;
        req1_s[0] = 1'b0;
        chkn("cont_ack_count", 0, n, 4);
        if (n > 0) chkn("cont_first_latency", 0, when[0] - c0, 4);
        for (int i = 0; i < n; i++) chkn("cont_order", 0, order[i], i % 2);
        for (int i = 1; i < n; i++) chkn("cont_spacing", 0, when[i] - when[i-1], 5);
        chk8("cont_rdata", 0, rdata_o[0], 8'h5A);

        // Swept timing: SETUP=3, STROBE=1, HOLD=2.
        access(1, 1'b0, 1'b1, 2'd2, 8'hC3, lat);
        chkn("sweep_wr_latency", 1, lat, 6);
        chkn("sweep_wr_width", 1, $countones(tr_wr), 1);
        chk8("sweep_cs_trace", 1, 8'(tr_cs[6:0]), 8'h7E);
        din_s[1] = 8'h6E;
        access(1, 1'b1, 1'b0, 2'd1, 8'h00, lat);
        chkn("sweep_rd_latency", 1, lat, 6);
        chkn("sweep_rd_width", 1, $countones(tr_rd), 1);
        chk1("sweep_rd_pos", 1, tr_rd[4], 1'b1);
        chk8("sweep_rdata", 1, rd_ack, 8'h6E);

        // Reset during STROBE: outputs clear at once and the access is dropped.
        tick();
        we0_s[0] = 1'b1; addr0_s[0] = 2'd3; wdata0_s[0] = 8'hF0; req0_s[0] = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (wr_o[0] === 1'b1) seen = 1'b1;
        end
        chk1("rst_strobe_seen", 0, seen, 1'b1);
        @(posedge clk);
        #2;
        rst_s[0] = 1'b0;
        req0_s[0] = 1'b0;
        #1;
        chk1("async_cs", 0, cs_o[0], 1'b0);
        chk1("async_wr", 0, wr_o[0], 1'b0);
        chk1("async_busy", 0, busy_o[0], 1'b0);
        chk1("async_ack0", 0, ack0_o[0], 1'b0);
        chk8("async_a", 0, 8'(a_o[0]), 8'h00);
        chk8("async_dout", 0, dout_o[0], 8'h00);
        chk8("async_rdata", 0, rdata_o[0], 8'h00);
        repeat (2) tick();
        rst_s[0] = 1'b1;
        repeat (12) tick();
        access(0, 1'b0, 1'b1, 2'd1, 8'h96, lat);
        chkn("post_rst_latency", 0, lat, 4);
        chk8("post_rst_a", 0, 8'(a_at2), 8'h01);
        chk8("post_rst_dout", 0, d_at2, 8'h96);

        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/i8255_sched.md
# i8255_sched

Two-requester bus scheduler for the i8255 register interface. It arbitrates between two internal requesters, port 0 and port 1, using round-robin. It then sequences each granted register access onto the i8255 CPU-side bus (`cs`, `rd`, `wr`, `a`, data), with programmable setup, strobe and hold phases, and returns read data with a one-cycle acknowledge. It sits between the system fabric and `i8255`, replacing a direct CPU connection.

## Interface
Parameters:
- `SETUP_CYC`, default 1: cycles of `cs`/`a`/data valid before the strobe. Range 1..15.
- `STROBE_CYC`, default 2: cycles `rd` or `wr` is held high. Range 1..15.
- `HOLD_CYC`, default 1: cycles `cs`/`a`/data stay valid after the strobe. Range 1..15.
- `INIT_CTRL`, default 8'h9B: control word written at start-up when `I8255_SCHED_INIT_EN` is defined.

Ports:
- `clk`, input, 1: single clock. All logic is on its rising edge.
- `reset`, input, 1: asynchronous, active-low reset (0 = reset).
- `req0`, `req1`, input, 1 each: access request from requester 0 / 1.
- `we0`, `we1`, input, 1 each: 1 = write, 0 = read.
- `addr0`, `addr1`, input, 2 each: i8255 register address.
- `wdata0`, `wdata1`, input, 8 each: write data.
- `ack0`, `ack1`, output, 1 each: one-cycle completion pulse.
- `rdata`, output, 8: read data, valid in the `ackN` cycle of a read, and held until the next read completes.
- `busy`, output, 1: high in every non-IDLE state.
- `cs`, `rd`, `wr`, output, 1 each: i8255 bus strobes, positive logic.
- `a`, output, 2: i8255 address.
- `dout`, output, 8: write data to the i8255 `din`.
- `din`, input, 8: read data from the i8255 `dout`.

## Operation
- FSM states: IDLE, SETUP, STROBE, HOLD. With the macro defined, an additional INIT state exists.
- **IDLE**
  - If any `reqN` is high, latch the granted port's `we`, `addr` and `wdata` into internal registers and go to SETUP.
  - The counter loads `SETUP_CYC-1`.
- **SETUP**
  - `cs=1`; `a` and `dout` are driven from the latched values; `rd=wr=0`.
  - When the counter reaches 0, go to STROBE. The counter loads `STROBE_CYC-1`.
- **STROBE**
  - `cs=1`, and `wr=we` / `rd=!we`.
  - On the last STROBE cycle of a read, register `din` into `rdata`.
  - Then go to HOLD. The counter loads `HOLD_CYC-1`.
- **HOLD**
  - `cs=1`, `rd=wr=0`; `a` and `dout` are unchanged.
  - On the last HOLD cycle, pulse `ackN` for the granted port, then go to IDLE.
- **Arbitration**
  - A `last` pointer resets to 1, so port 0 wins the first contention.
  - When both ports request, the grant goes to the port not equal to `last`.
  - `last` updates to the granted port at grant time.
  - A single requester is always granted.
- **Request rules**
  - A requester holds `req`, `we`, `addr` and `wdata` stable until it sees its `ack`.
  - Because request fields are latched at grant, changes after grant have no effect.
  - Dropping `req` mid-transaction does not abort it; the access completes and `ack` still pulses.
  - `req` sampled high in IDLE after an `ack` is a new request. Back-to-back accesses are permitted.
- **Bus outputs in IDLE:** `cs=rd=wr=0`; `a` and `dout` hold their last values.
- **`rd`/`wr` exclusivity:** `rd` and `wr` are never high in the same cycle. `rd`/`wr` is never asserted without `cs`.

## Timing
- **Reset values:** `cs=rd=wr=0`, `a=0`, `dout=0`, `rdata=0`, `ack0=ack1=0`, `busy=0`, state IDLE (or INIT with the macro), `last=1`.
- **Latency:** with `req` sampled high in IDLE at cycle 0, `cs` rises at cycle 1.
  - The strobe occupies cycles `1+SETUP_CYC` through `SETUP_CYC+STROBE_CYC`.
  - `ack` is high in cycle `SETUP_CYC+STROBE_CYC+HOLD_CYC`.
  - IDLE follows; the next grant is at the earliest one cycle later.
  - With defaults, `ack` arrives at cycle 4 and the throughput is one access per 5 cycles.
- **Reset mid-operation:** asserting `reset` during any state immediately forces all reset values. The in-flight access is lost and no `ack` is issued.
- **Simultaneous requests:** when both ports request and one gets `ack`, the other is granted in the following IDLE cycle.

## Configuration
- Macro `I8255_SCHED_INIT_EN`.
- **Defined**
  - Reset enters INIT. After reset release, the block performs one write of `INIT_CTRL` to `a=2'b11`, using the normal SETUP/STROBE/HOLD sequence with no `ack` pulse.
  - `busy=1` throughout, and requests wait. The FSM then enters IDLE.
- **Undefined:** reset enters IDLE directly and the i8255 keeps its own reset configuration.

## Test plan
- **Single write, defaults:** port 0 requests a write of 8'h55 to addr 0 at cycle 0.
  - `cs` is high in cycles 1–4; `wr` is high in cycles 2–3; `a=0` and `dout=8'h55` throughout; `ack0` is high in cycle 4 only.
- **Single read:** port 1 requests a read of addr 2 while `din=8'hA7`.
  - `rd` is high for 2 cycles; `rdata=8'hA7` in the `ack1` cycle; `wr` stays 0.
- **Contention:** `req0` and `req1` are asserted in the same cycle and held.
  - Grant order is 0, 1, 0, 1 across four accesses; `ack`s are 5 cycles apart.
- **Parameter sweep:** run with SETUP=3, STROBE=1, HOLD=2.
  - `ack` arrives at cycle 6 after `req`; the strobe is 1 cycle wide.
- **Reset mid-access:** drop `reset` to 0 during STROBE.
  - All outputs go to 0 immediately; no `ack`; after release, a new request completes normally.
- **Init build (macro defined):**
  - After reset release, a write of 8'h9B to `a=3` completes before any `ack`.
  - A `req0` held from reset is serviced afterwards.
